// File: rtl/rf_uart_dump.sv
// Walks every register-file entry through one read port and prints each one as
// an ASCII line "A:DD\r\n" over an 8N1 UART transmitter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle high, waiting for a start request
// FETCH     | capture data_rs for the current address, restart char index
// LOAD_CHAR | latch the next character byte of the line
// START_BIT | tx low for one bit time
// DATA_BITS | eight data bits, LSB first
// STOP_BIT  | tx high for one bit time
// NEXT      | advance char index, or address, or finish the dump
// FINISH    | one-cycle done pulse, address wraps to 0
module rf_uart_dump #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] addr_rs,
  input  logic [W-1:0] data_rs,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int HEX      = W / 4;
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW       = $clog2(HEX + 4);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(HEX + 3);
  localparam logic [N-1:0]  ADDR_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD_CHAR, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  shadow;
  logic [CW-1:0] char_idx;
  logic [7:0]    char_byte;
  logic [7:0]    char_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          baud_tc;

  assign baud_tc = (baud_cnt == '0);

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction

  // Character for the current index; shadow holds the line's data snapshot.
  always_comb begin
    char_nxt = 8'h0A;
    if (char_idx == '0) begin
      char_nxt = hex_ascii(4'(addr_rs));
    end else if (char_idx == CW'(1)) begin
      char_nxt = 8'h3A;
    end else if (char_idx == CW'(HEX + 2)) begin
      char_nxt = 8'h0D;
    end else begin
      for (int k = 0; k < HEX; k++) begin
        if (char_idx == CW'(k + 2)) char_nxt = hex_ascii(shadow[(HEX-1-k)*4 +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     state_nxt = LOAD_CHAR;
      LOAD_CHAR: state_nxt = START_BIT;
      START_BIT: if (baud_tc) state_nxt = DATA_BITS;
      DATA_BITS: if (baud_tc && bit_cnt == 3'd7) state_nxt = STOP_BIT;
      STOP_BIT:  if (baud_tc) state_nxt = NEXT;
      NEXT: begin
        if (char_idx != CHAR_LAST)     state_nxt = LOAD_CHAR;
        else if (addr_rs != ADDR_LAST) state_nxt = FETCH;
        else                           state_nxt = FINISH;
      end
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != IDLE) && (state != FINISH);
    done = (state == FINISH);
    case (state)
      START_BIT: tx = 1'b0;
      DATA_BITS: tx = char_byte[bit_cnt];
      default:   tx = 1'b1;
    endcase
  end

  // Bit timer is a down-counter reloaded at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_rs   <= '0;
      shadow    <= '0;
      char_idx  <= '0;
      char_byte <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        FETCH: begin
          shadow   <= data_rs;
          char_idx <= '0;
        end
        LOAD_CHAR: begin
          char_byte <= char_nxt;
          baud_cnt  <= BAUD_LAST;
          bit_cnt   <= '0;
        end
        START_BIT, STOP_BIT: begin
          if (baud_tc) baud_cnt <= BAUD_LAST;
          else         baud_cnt <= baud_cnt - BW'(1);
        end
        DATA_BITS: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        NEXT: begin
          if (char_idx != CHAR_LAST)     char_idx <= char_idx + CW'(1);
          else if (addr_rs != ADDR_LAST) addr_rs  <= addr_rs + N'(1);
        end
        FINISH:  addr_rs <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_uart_dump.sv
// Bench for rf_uart_dump at a short bit time: a UART receiver decodes tx and
// checks every byte against a queue of expected characters.
module tb_rf_uart_dump;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BD       = CLK_FREQ / BAUD;
  localparam int DUR      = 96 * 10 * BD + 96 * 2 + 16 + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] addr_rs;
  logic [W-1:0] data_rs;
  logic         tx, busy, done;
  logic [W-1:0] regs [16];

  assign data_rs = regs[addr_rs];

  always #5 clk = ~clk;

  rf_uart_dump #(.N(N), .W(W), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_rs(addr_rs),
    .data_rs(data_rs), .tx(tx), .busy(busy), .done(done)
  );

  int cyc = 0;
  int done_cnt = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  string hexs = "0123456789ABCDEF";

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    int         off;
    logic       tx;
    logic       busy;
    logic [3:0] addr;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_dump();
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(hexs[a]);
      exp_q.push_back(8'h3A);
      exp_q.push_back(hexs[int'(regs[a][7:4])]);
      exp_q.push_back(hexs[int'(regs[a][3:0])]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // UART receiver: sample mid-bit, drop any frame that overlaps a reset.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       ab;
    logic       stop_bit;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (prev && !tx && !rst) begin
        ab = 1'b0;
        repeat (4) begin @(negedge clk); if (rst) ab = 1'b1; end
        for (int i = 0; i < 8; i++) begin
          repeat (BD) begin @(negedge clk); if (rst) ab = 1'b1; end
          b[i] = tx;
        end
        repeat (BD) begin @(negedge clk); if (rst) ab = 1'b1; end
        stop_bit = tx;
        if (!ab) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_extra: got byte 0x%0h with no byte expected", b);
          end else begin
            check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
            check("rx_stop", 32'(stop_bit), 32'd1);
          end
        end
      end
      prev = tx;
    end
  end

  task automatic dump_check(input int pulse);
    int  t0, dur, d0;
    bit  ok;
    push_dump();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 1; k < 15000; k++) begin
      if (done) begin ok = 1'b1; break; end
      start = (pulse > 0) && (k % pulse == 0);
      @(negedge clk);
    end
    start = 1'b0;
    dur = cyc - t0;
    check("done_seen", 32'(ok), 32'd1);
    check($sformatf("duration_%0d", dur), 32'(dur >= DUR - 1 && dur <= DUR + 1), 32'd1);
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("addr_after", 32'(addr_rs), 32'd0);
    check("tx_after", 32'(tx), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lows, d0;
    bit found;
    // First frame '0' = 0x30: start, bits 0,0,0,0,1,1,0,0, stop.
    tbl[0]  = '{1,   1'b1, 1'b1, 4'd0};
    tbl[1]  = '{2,   1'b1, 1'b1, 4'd0};
    tbl[2]  = '{3,   1'b0, 1'b1, 4'd0};
    tbl[3]  = '{12,  1'b0, 1'b1, 4'd0};
    tbl[4]  = '{13,  1'b0, 1'b1, 4'd0};
    tbl[5]  = '{52,  1'b0, 1'b1, 4'd0};
    tbl[6]  = '{53,  1'b1, 1'b1, 4'd0};
    tbl[7]  = '{62,  1'b1, 1'b1, 4'd0};
    tbl[8]  = '{72,  1'b1, 1'b1, 4'd0};
    tbl[9]  = '{73,  1'b0, 1'b1, 4'd0};
    tbl[10] = '{92,  1'b0, 1'b1, 4'd0};
    tbl[11] = '{93,  1'b1, 1'b1, 4'd0};
    tbl[12] = '{102, 1'b1, 1'b1, 4'd0};
    tbl[13] = '{103, 1'b1, 1'b1, 4'd0};
    tbl[14] = '{104, 1'b1, 1'b1, 4'd0};
    tbl[15] = '{105, 1'b0, 1'b1, 4'd0};

    for (int i = 0; i < 16; i++) regs[i] = 8'(17 * i);
    regs[0] = 8'hA5;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(addr_rs), 32'd0);
    lows = 0;
    repeat (100) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("idle_tx_low_cycles", 32'(lows), 32'd0);

    // Dump 1: reg0=0xA5, bit-level timing of the first frame from the table.
    fork
      dump_check(0);
      begin
        @(negedge clk);
        for (int k = 1; k <= 105; k++) begin
          @(negedge clk);
          foreach (tbl[i]) begin
            if (tbl[i].off == k) begin
              check($sformatf("tbl_tx_%0d", k), 32'(tx), 32'(tbl[i].tx));
              check($sformatf("tbl_busy_%0d", k), 32'(busy), 32'(tbl[i].busy));
              check($sformatf("tbl_addr_%0d", k), 32'(addr_rs), 32'(tbl[i].addr));
            end
          end
        end
      end
    join

    // Dump 2: reg i = 0x11*i, start re-pulsed every 50 clocks while busy.
    regs[0] = 8'h00;
    dump_check(50);

    // Dump 3: reg3 overwritten while its line is on the wire.
    regs[3] = 8'h33;
    fork
      dump_check(0);
      begin
        for (int k = 0; k < 5000 && addr_rs != 4'd3; k++) @(negedge clk);
        repeat (40) @(negedge clk);
        regs[3] = 8'h7C;
      end
    join
    check("reg3_line_snapshot", 32'(addr_rs), 32'd0);
    dump_check(0);

    // Reset in the middle of a data bit on line 5.
    push_dump();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (addr_rs == 4'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("reach_line5", 32'(found), 32'd1);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(addr_rs), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle_tx", 32'(tx), 32'd1);
    dump_check(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
